// File: rtl/riscv_pipeline_pkg.sv
// Shared definitions for the pipeline data-memory responder.
package riscv_pipeline_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  localparam int unsigned DMEM_DEPTH       = 256;
  localparam int unsigned DMEM_WAIT_CYCLES = 2;
  localparam int unsigned DMEM_MAX_WAIT    = 7;

  // Access is illegal when misaligned, below the window, or past its last word.
  function automatic logic dmem_addr_err(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int unsigned depth);
    logic [31:0] off;
    off = addr - base;
    return (addr[1:0] != 2'b00) || (addr < base) || ((off >> 2) >= depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with byte-enabled synchronous write and registered read.
module dmem_array #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Byte-lane writes and read-data capture; contents are never reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be_i[2'(i)]) begin
          mem_q[addr_i][{i[1:0], 3'b000} +: 8] <= wdata_i[{i[1:0], 3'b000} +: 8];
        end
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: request capture, programmable
// wait states, address checking and a held response toward the pipeline.
module dmem_responder
  import riscv_pipeline_pkg::*;
#(
  parameter int unsigned DEPTH       = DMEM_DEPTH,
  parameter int unsigned WAIT_CYCLES = DMEM_WAIT_CYCLES,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0]  CNT_LOAD = (WAIT_CYCLES == 0) ? 3'd0 : 3'(WAIT_CYCLES - 1);

  if (WAIT_CYCLES > DMEM_MAX_WAIT) begin : g_bad_wait
    $error("dmem_responder: WAIT_CYCLES must be 0..7");
  end

  dmem_state_e state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic          sel_we;
  logic [31:0]   sel_addr;
  logic [31:0]   sel_wdata;
  logic [3:0]    sel_be;
  logic          addr_err;
  logic          acc_en;
  logic          arr_we;
  logic          arr_re;
  logic [AW-1:0] arr_idx;
  logic [31:0]   arr_rdata;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // With zero wait states the array is accessed on the acceptance edge itself,
  // before the holding registers are loaded, so the live request is steered in.
  always_comb begin
    sel_we    = we_q;
    sel_addr  = addr_q;
    sel_wdata = wdata_q;
    sel_be    = be_q;
    if (state_q == IDLE) begin
      sel_we    = req_we;
      sel_addr  = req_addr;
      sel_wdata = req_wdata;
      sel_be    = req_be;
    end
  end

  assign addr_err = dmem_addr_err(sel_addr, BASE_ADDR, DEPTH);
  assign arr_idx  = AW'((sel_addr - BASE_ADDR) >> 2);
  assign arr_we   = acc_en &  sel_we & ~addr_err;
  assign arr_re   = acc_en & ~sel_we & ~addr_err;

  // Next-state, counter, holding-register and response decode.
  // RESP spends its first cycle latching the array result into the response
  // registers; rsp_valid rises on the following edge and then holds.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    acc_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            acc_en  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = RESP;
          acc_en  = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = addr_err;
          rsp_rdata_d = (we_q || addr_err) ? '0 : arr_rdata;
        end else if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and response registers; reset abandons any access in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  dmem_array #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_array (
    .clk_i  (clock),
    .we_i   (arr_we),
    .be_i   (sel_be),
    .addr_i (arr_idx),
    .wdata_i(sel_wdata),
    .re_i   (arr_re),
    .rdata_o(arr_rdata)
  );

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameters SHALL be one per line as name, default, meaning:
- DEPTH, 256, number of 32-bit words stored.
- WAIT_CYCLES, 2, extra wait states per access; legal range 0..7.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
REQ-002 Ports SHALL be one per line as name, direction, width, meaning:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  pipeline MEM stage presents a request.
- req_ready  out  1  responder can accept a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address.
- req_wdata  in  32  write data.
- req_be  in  4  byte enables; bit i covers wdata[8i+7:8i].
- rsp_valid  out  1  response available.
- rsp_ready  in  1  requester consumes the response.
- rsp_rdata  out  32  read data; 0 for writes and errors.
- rsp_err  out  1  access was misaligned or out of range.

Function
REQ-003 The FSM SHALL have three states, IDLE, WAIT and RESP, with one request outstanding at most.
REQ-004 req_ready SHALL be 1 only in IDLE and SHALL be decoded from state alone, never from req_valid.
REQ-005 A handshake (req_valid && req_ready at an edge) SHALL capture we, addr, wdata and be into holding registers.
- If WAIT_CYCLES = 0, the next state SHALL be RESP.
- Otherwise, the next state SHALL be WAIT with the counter loaded to WAIT_CYCLES-1.
REQ-006 WAIT SHALL decrement the counter each cycle and move to RESP on the edge where the counter equals 0.
REQ-007 Latency: a request accepted at edge N SHALL produce rsp_valid=1 after edge N+1+WAIT_CYCLES.
REQ-008 The memory access SHALL occur on the edge that enters RESP.
- Write: only enabled bytes are updated.
- Read: rsp_rdata is registered from the addressed word.
REQ-009 Error condition SHALL be any of: addr[1:0] != 0; addr < BASE_ADDR; (addr-BASE_ADDR)>>2 >= DEPTH.
- On error: no write, rsp_rdata = 0, rsp_err = 1.
REQ-010 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL be held stable until rsp_ready=1.
- That edge returns to IDLE and clears rsp_valid, rsp_rdata and rsp_err to 0.
REQ-011 Back-to-back accesses SHALL have an earliest next acceptance one cycle after the response handshake, giving a minimum throughput of one access per WAIT_CYCLES+3 cycles.
REQ-012 A write with req_be = 4'b0000 SHALL complete as a normal acknowledge with no array change and rsp_err=0.
REQ-013 A read following a write to the same word SHALL return the post-write data.
REQ-014 req_valid while not in IDLE SHALL be ignored; the requester must hold the request until the handshake.

Reset
REQ-015 While reset=0, the block SHALL force:
- state = IDLE, counter = 0, holding registers = 0;
- req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
REQ-016 The storage array SHALL NOT be reset; read-before-write contents are undefined.
REQ-017 Reset asserted in WAIT or RESP SHALL abandon the access.
- A write not yet committed (still in WAIT) SHALL leave the array unchanged.

Structure
REQ-018 The FSM state encodings (IDLE=2'd0, WAIT=2'd1, RESP=2'd2) and the default DEPTH/WAIT_CYCLES constants SHALL live in the shared package riscv_pipeline_pkg.
REQ-019 Storage SHALL be a single sub-module dmem_array: synchronous byte-enabled write, registered read, no reset.
- The FSM, counter, address checking and handshake SHALL live in dmem_responder.

Verification
REQ-020 The bench SHALL cover these directed scenarios at WAIT_CYCLES=2:
- Write addr 0x10, wdata 0xDEADBEEF, be 4'hF, accepted at edge N -> rsp_valid at edge N+3, rsp_err=0; then read 0x10 -> rsp_rdata 0xDEADBEEF.
- Write 0x10 with wdata 0x000000AA, be 4'b0001 -> subsequent read returns 0xDEADBEAA.
- Read addr 0x13 -> rsp_err=1, rsp_rdata=0; read 0x400 (DEPTH=256) -> rsp_err=1; no array change in either case.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata, rsp_err stable and req_ready=0 throughout; the ready edge returns to IDLE.
- Assert reset during WAIT of a write to 0x20 holding 0x11111111 -> outputs at reset values immediately; a later read of 0x20 returns 0x11111111.
- Rebuild with WAIT_CYCLES=0, continuous req_valid and rsp_ready -> one access every 3 cycles, no request lost.
